// File: rtl/soc_event_queue.sv
// -----------------------------------------------------------------------------
// soc_event_queue
//
// Serialises one-cycle uDMA event pulses into an ordered queue of event IDs.
// Simultaneous pulses are latched as pending bits. A round-robin selector
// drains them, one per cycle, into a small FIFO. The consumer pops IDs with a
// valid/ready handshake. A repeat of an event that is still pending is
// coalesced and reported through a sticky overflow flag.
//
// Ports
//   clk_i           SoC clock
//   rst_ni          synchronous, active-low reset
//   events_i        event pulse vector, one bit per event
//   evt_valid_o     FIFO head valid
//   evt_id_o        FIFO head event ID (0 when not valid)
//   evt_ready_i     consumer accepts the head
//   fifo_count_o    number of IDs held in the FIFO
//   pending_o       at least one event is pending
//   overflow_o      sticky: an occurrence was coalesced
//   overflow_id_o   ID of the first coalesced event since the last clear
//   clr_overflow_i  clears overflow_o and overflow_id_o
// -----------------------------------------------------------------------------
module soc_event_queue #(
    parameter int NUM_EVENTS = 124,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_WIDTH  = $clog2(NUM_EVENTS),
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic                  evt_valid_o,
    output logic [ID_WIDTH-1:0]   evt_id_o,
    input  logic                  evt_ready_i,
    output logic [CNT_WIDTH-1:0]  fifo_count_o,
    output logic                  pending_o,
    output logic                  overflow_o,
    output logic [ID_WIDTH-1:0]   overflow_id_o,
    input  logic                  clr_overflow_i
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    logic [NUM_EVENTS-1:0] pending_q, pending_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [ID_WIDTH-1:0]   overflow_id_q, overflow_id_d;

    logic                  sel_found;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  found_hi, found_lo;
    logic [ID_WIDTH-1:0]   sel_hi, sel_lo;
    logic                  push, pop;
    logic                  coal_any;
    logic [ID_WIDTH-1:0]   coal_id;

    // Round-robin pick. Scanning downwards leaves the lowest set index in
    // sel_lo, and the lowest set index at or above rr_ptr in sel_hi. The
    // wrap-around case falls back to sel_lo.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                found_lo = 1'b1;
                sel_lo   = ID_WIDTH'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    sel_hi   = ID_WIDTH'(i);
                end
            end
        end
        sel_found = found_lo;
        sel_id    = found_hi ? sel_hi : sel_lo;
    end

    // A full FIFO can still accept a push when the head leaves in the same
    // cycle, so a drain does not cost a cycle of throughput.
    always_comb begin
        pop  = (count_q != '0) && evt_ready_i;
        push = sel_found && ((count_q != CNT_WIDTH'(FIFO_DEPTH)) || pop);
    end

    // Pending bits. A new pulse on the bit that is being pushed re-arms it.
    // A pulse on a bit that stays pending is coalesced. The downward scan
    // leaves the lowest coalesced index in coal_id.
    always_comb begin
        pending_d = pending_q;
        coal_any  = 1'b0;
        coal_id   = '0;
        if (push) begin
            pending_d[sel_id] = 1'b0;
        end
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (events_i[i]) begin
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(push && (sel_id == ID_WIDTH'(i)))) begin
                    coal_any = 1'b1;
                    coal_id  = ID_WIDTH'(i);
                end
            end
        end
    end

    // Round-robin pointer moves past the pushed ID, wrapping at the top.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel_id == ID_WIDTH'(NUM_EVENTS - 1)) ? '0 : sel_id + 1'b1;
        end
    end

    // FIFO storage and pointers. The depth is a power of two, so the pointers
    // wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky overflow. Only the first coalesced ID is kept. A clear in the
    // same cycle as a fresh coalesce yields to the fresh coalesce.
    always_comb begin
        overflow_d    = overflow_q;
        overflow_id_d = overflow_id_q;
        if (coal_any) begin
            overflow_d = 1'b1;
            if (!overflow_q || clr_overflow_i) begin
                overflow_id_d = coal_id;
            end
        end else if (clr_overflow_i) begin
            overflow_d    = 1'b0;
            overflow_id_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            overflow_id_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            overflow_id_q <= overflow_id_d;
            mem_q         <= mem_d;
        end
    end

    // All outputs are decoded from registered state only.
    always_comb begin
        evt_valid_o   = (count_q != '0);
        evt_id_o      = evt_valid_o ? mem_q[rd_ptr_q] : '0;
        fifo_count_o  = count_q;
        pending_o     = |pending_q;
        overflow_o    = overflow_q;
        overflow_id_o = overflow_id_q;
    end

endmodule

// File: tb/tb_soc_event_queue.sv
// -----------------------------------------------------------------------------
// tb_soc_event_queue
//
// Directed scenarios followed by a random phase. A reference model holds the
// pending events as a bit array and the FIFO as a queue of IDs. The model
// predicts every output after every clock edge. Some directed steps also
// carry fixed expected values.
// -----------------------------------------------------------------------------
module tb_soc_event_queue;

    localparam int NE    = 124;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NE-1:0] events_i;
    logic          evt_valid_o;
    logic [6:0]    evt_id_o;
    logic          evt_ready_i;
    logic [3:0]    fifo_count_o;
    logic          pending_o;
    logic          overflow_o;
    logic [6:0]    overflow_id_o;
    logic          clr_overflow_i;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state
    bit modelPend [NE];
    int modelRr;
    int modelQ [$];
    bit modelOvf;
    int modelOvfId;

    soc_event_queue dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .events_i       (events_i),
        .evt_valid_o    (evt_valid_o),
        .evt_id_o       (evt_id_o),
        .evt_ready_i    (evt_ready_i),
        .fifo_count_o   (fifo_count_o),
        .pending_o      (pending_o),
        .overflow_o     (overflow_o),
        .overflow_id_o  (overflow_id_o),
        .clr_overflow_i (clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [NE-1:0] evBit(input int i);
        logic [NE-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        foreach (modelPend[i]) modelPend[i] = 1'b0;
        modelRr    = 0;
        modelQ.delete();
        modelOvf   = 1'b0;
        modelOvfId = 0;
    endtask

    // One clock of behaviour, taken from the current model state and the
    // inputs applied for the coming edge.
    task automatic modelStep(input logic [NE-1:0] ev, input logic rdy, input logic clr);
        bit pop, push, found, coal;
        int j, low;
        pop   = (modelQ.size() != 0) && rdy;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NE; k++) begin
            int idx;
            idx = (modelRr + k) % NE;
            if (!found && modelPend[idx]) begin
                found = 1'b1;
                j     = idx;
            end
        end
        push = found && ((modelQ.size() < DEPTH) || pop);
        coal = 1'b0;
        low  = 0;
        for (int i = 0; i < NE; i++) begin
            if (ev[i] && modelPend[i] && !(push && i == j)) begin
                if (!coal) low = i;
                coal = 1'b1;
            end
        end
        if (pop) void'(modelQ.pop_front());
        if (push) begin
            modelQ.push_back(j);
            modelPend[j] = 1'b0;
            modelRr      = (j + 1) % NE;
        end
        for (int i = 0; i < NE; i++) begin
            if (ev[i]) modelPend[i] = 1'b1;
        end
        if (coal) begin
            if (!modelOvf || clr) modelOvfId = low;
            modelOvf = 1'b1;
        end else if (clr) begin
            modelOvf   = 1'b0;
            modelOvfId = 0;
        end
    endtask

    task automatic checkOutput();
        bit anyPend;
        anyPend = 1'b0;
        foreach (modelPend[i]) anyPend |= modelPend[i];
        checkOne("evt_valid",   evt_valid_o,   32'(modelQ.size() != 0));
        checkOne("evt_id",      evt_id_o,      (modelQ.size() != 0) ? modelQ[0] : 0);
        checkOne("fifo_count",  fifo_count_o,  modelQ.size());
        checkOne("pending",     pending_o,     32'(anyPend));
        checkOne("overflow",    overflow_o,    32'(modelOvf));
        checkOne("overflow_id", overflow_id_o, modelOvfId);
    endtask

    task automatic applyStimulus(input logic [NE-1:0] ev, input logic rdy, input logic clr);
        events_i       = ev;
        evt_ready_i    = rdy;
        clr_overflow_i = clr;
        modelStep(ev, rdy, clr);
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    // Reset with random pulses present; the pulses must be ignored.
    task automatic doReset(input int cycles);
        rst_ni = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            events_i       = {$urandom, $urandom, $urandom, $urandom};
            evt_ready_i    = 1'b1;
            clr_overflow_i = 1'b0;
            @(posedge clk_i);
            #1;
        end
        rst_ni   = 1'b1;
        events_i = '0;
        modelClear();
        checkOutput();
    endtask

    initial begin
        logic [NE-1:0] ev;
        logic [NE-1:0] twelve;
        rst_ni         = 1'b0;
        events_i       = '0;
        evt_ready_i    = 1'b0;
        clr_overflow_i = 1'b0;
        modelClear();

        // Reset, then idle for 20 cycles
        doReset(2);
        checkOne("reset_valid", evt_valid_o, 0);
        checkOne("reset_count", fifo_count_o, 0);
        for (int c = 0; c < 20; c++) applyStimulus('0, 1'b0, 1'b0);

        // Single pulse on event 5: visible two edges later, for one cycle
        applyStimulus(evBit(5), 1'b1, 1'b0);
        checkOne("ev5_not_yet", evt_valid_o, 0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("ev5_valid", evt_valid_o, 1);
        checkOne("ev5_id", evt_id_o, 5);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("ev5_gone", evt_valid_o, 0);

        // Event 123 wraps the round-robin pointer back to 0
        applyStimulus(evBit(123), 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("ev123_id", evt_id_o, 123);
        applyStimulus('0, 1'b1, 1'b0);

        // Events 3, 40 and 100 together are delivered in index order
        applyStimulus(evBit(3) | evBit(40) | evBit(100), 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("trio_first", evt_id_o, 3);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("trio_second", evt_id_o, 40);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("trio_third", evt_id_o, 100);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("trio_done", evt_valid_o, 0);

        // Pushing event 4 leaves rr_ptr at 5; then 10 is served before 2
        applyStimulus(evBit(4), 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus(evBit(10) | evBit(2), 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("rr_first", evt_id_o, 10);
        applyStimulus('0, 1'b1, 1'b0);
        checkOne("rr_second", evt_id_o, 2);
        applyStimulus('0, 1'b1, 1'b0);

        // Backpressure: 12 distinct events with the consumer stalled
        twelve = '0;
        for (int i = 20; i < 32; i++) twelve[i] = 1'b1;
        applyStimulus(twelve, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) applyStimulus('0, 1'b0, 1'b0);
        checkOne("bp_full", fifo_count_o, 8);
        checkOne("bp_pending", pending_o, 1);
        checkOne("bp_no_ovf", overflow_o, 0);
        checkOne("bp_head_stable", evt_id_o, 20);
        for (int c = 0; c < 14; c++) applyStimulus('0, 1'b1, 1'b0);
        checkOne("bp_drained", fifo_count_o, 0);
        checkOne("bp_no_pending", pending_o, 0);

        // Overflow: FIFO full, event 7 pulsed twice, three cycles apart
        ev = '0;
        for (int i = 40; i < 48; i++) ev[i] = 1'b1;
        applyStimulus(ev, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(evBit(7), 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(evBit(7), 1'b0, 1'b0);
        checkOne("ovf_flag", overflow_o, 1);
        checkOne("ovf_id", overflow_id_o, 7);
        applyStimulus('0, 1'b0, 1'b1);
        checkOne("ovf_cleared", overflow_o, 0);
        for (int c = 0; c < 12; c++) applyStimulus('0, 1'b1, 1'b0);
        checkOne("ovf_drained", fifo_count_o, 0);

        // Reset mid-operation with the FIFO half full, bits pending and overflow set
        twelve = '0;
        for (int i = 60; i < 72; i++) twelve[i] = 1'b1;
        applyStimulus(twelve, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(evBit(71), 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOne("mid_count", fifo_count_o, 4);
        checkOne("mid_ovf", overflow_o, 1);
        doReset(1);
        checkOne("rst_count", fifo_count_o, 0);
        checkOne("rst_pending", pending_o, 0);
        checkOne("rst_ovf", overflow_o, 0);
        for (int c = 0; c < 15; c++) applyStimulus('0, 1'b1, 1'b0);

        // Random traffic; low IDs are reused often to provoke coalescing
        for (int c = 0; c < 1500; c++) begin
            int n;
            ev = '0;
            n  = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 0) ev[$urandom_range(0, 7)] = 1'b1;
                else                           ev[$urandom_range(0, NE - 1)] = 1'b1;
            end
            applyStimulus(ev, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
